control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired multi-cycle control unit for the 32-bit CPU.
- Sequences the datapath register/bus/ALU strobes and the 512x32 RAM handshake through fetch, decode and execute.
- Sits beside the datapath at system level. It reads IR, the CON flip-flop bit and the RAM done flag, and drives every control input those two blocks take.

Parameters:
- DATA_WIDTH, 32, instruction/IR width.
- ADD_OP, 5'b00011, ALU opcode used for PC/address arithmetic.
- MEM_TIMEOUT, 16, max cycles waiting on memory_done before fault (0 = wait forever).

Ports:
- Clock  in  1  system clock, rising edge.
- clear  in  1  synchronous active-high reset.
- IR  in  DATA_WIDTH  instruction register contents; op = IR[31:27].
- con_ff_bit  in  1  branch condition from datapath.
- memory_done  in  1  RAM completion flag.
- HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout  out  1 each  bus source selects.
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in  out  1 each  register enables.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-select controls.
- opcode  out  5  ALU operation.
- IncPC  out  1  ALU PC-increment.
- Mem_Read, Mem_Write, Mem_enable512x32  out  1 each  RAM controls.
- halted  out  1  CPU stopped (halt or fault).
- mem_fault  out  1  memory timeout occurred (sticky until clear).
- illegal_op  out  1  one-cycle pulse on undefined opcode.

Behaviour:
- Outputs are decoded combinationally from the registered state and IR, except where noted. All outputs are 0 in RESET.
- clear=1 forces state RESET at the edge, aborting any memory access; Mem_* are low the following cycle. RESET always proceeds to T0.
- T0: PCout, MARin, IncPC, Zin.
- T1 (fetch wait): Zlo_out, PCin on entry cycle only. Mem_Read and Mem_enable512x32 held until memory_done. MDRin = memory_done. Advance on memory_done.
- T2: MDRout, IRin. Next: the decode class of the new IR (IR visible from T3).
- Opcodes: ld 00000, ldi 00001, st 00010, add..shl 00011-01011, addi/andi/ori 01100-01110, div 01111, mul 10000, neg 10001, not 10010, br 10011, jal 10100, jr 10101, in 10110, out 10111, mflo 11000, mfhi 11001, nop 11010, halt 11011. 11100-11111 are illegal: pulse illegal_op, then go to T0.
- Execute steps (opcode = op in ALU Zin steps, ADD_OP in address steps, 0 otherwise):
  - ALU reg: Grb Rout Yin; Grc Rout Zin; Zlo_out Gra Rin.
  - ALU imm: Grb Rout Yin; Cout Zin; Zlo_out Gra Rin.
  - ldi: Grb BAout Yin; Cout Zin; Zlo_out Gra Rin.
  - ld: ldi address steps; Zlo_out MARin; memory wait as T1 (MDRin = memory_done); MDRout Gra Rin.
  - st: address steps; Zlo_out MARin; Gra Rout MDRin; Mem_Write and Mem_enable512x32 held until memory_done.
  - mul/div: Gra Rout Yin; Grb Rout Zin; Zlo_out LOin; Zhi_out HIin.
  - neg/not: Grb Rout Zin; Zlo_out Gra Rin.
  - br: Gra Rout CONin; PCout Yin; Cout Zin(ADD_OP); then if con_ff_bit, Zlo_out PCin; else no strobe.
  - jr: Gra Rout PCin.
  - jal: PCout Grb Rin (link in Rb); Gra Rout PCin.
  - in: Inport_out Gra Rin. out: Gra Rout outport_in.
  - mfhi: HIout Gra Rin. mflo: LOout Gra Rin.
  - nop: no strobes.
- The last execute step returns to T0.
- halt: enter HALT; halted=1; hold until clear.
- Memory timeout: a counter resets on entry to each wait state. If it reaches MEM_TIMEOUT without memory_done, enter HALT with mem_fault=1 and Mem_* deasserted. memory_done on the same cycle the count hits the limit counts as success.
- No two bus-source outputs are ever high in the same cycle.

Optional Feature:
- SINGLE_STEP_EN defined: adds input step (1 bit). The sequencer holds in T0 with all outputs 0 until step=1. One instruction then executes per step pulse; step held high steps once per instruction. clear still overrides.
- Undefined: no step port; free-running.

Test Plan:
- clear high 3 cycles, then low, memory_done returns 2 cycles after Mem_Read -> T0 strobes appear the first cycle after clear falls; IRin asserted exactly 1 cycle after the MDRin cycle.
- IR=add R1,R2,R3 -> sequence Grb/Rout/Yin, Grc/Rout/Zin with opcode=00011, Zlo_out/Gra/Rin; then T0.
- IR=st 0x40(R2), memory_done delayed 5 cycles -> Mem_Write and enable high continuously for 5 cycles; MARin precedes MDRin by 1 cycle.
- IR=br with con_ff_bit=0 and =1 -> PCin asserted only when 1; opcode=00011 on the Cout/Zin step.
- memory_done held low, MEM_TIMEOUT=16 -> halted=1, mem_fault=1 after 16 wait cycles; Mem_Read=0 afterwards; clear recovers with mem_fault=0.
- IR op=11110, then halt opcode -> illegal_op pulses 1 cycle, next fetch proceeds; halt sets halted=1 and no further strobes for 20 cycles.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired multi-cycle control unit for the 32-bit CPU. Walks fetch (T0..T2)
//   and an instruction-class dependent execute sequence, driving every datapath
//   strobe and the 512x32 RAM handshake. Outputs are decoded combinationally
//   from the registered state and IR; only halted/mem_fault come from registers.
//
//   Optional build macro SINGLE_STEP_EN: adds input `step`; the sequencer parks
//   in T0 with all outputs low until step=1, then runs one instruction. Holding
//   step high keeps it running one instruction after another.
//
//   Ports
//     Clock, clear            clock / synchronous active-high reset
//     IR, con_ff_bit          instruction register, branch condition
//     memory_done             RAM completion flag
//     HIout..Cout             bus source selects (never more than one high)
//     MARin..outport_in       register load enables
//     Gra Grb Grc Rin Rout BAout  register-file select controls
//     opcode, IncPC           ALU controls
//     Mem_Read Mem_Write Mem_enable512x32  RAM controls
//     halted, mem_fault, illegal_op        status
//
//   state  | meaning
//   RESET  | after clear, all outputs low
//   T0     | PC -> MAR, PC+1 -> Z
//   T1     | fetch wait (PC <- Z on entry cycle)
//   T2     | MDR -> IR
//   EX     | execute, step_q selects the step within the instruction class
//   HALT   | stopped by halt opcode or memory timeout, held until clear
module control_sequencer #(
  parameter int         DATA_WIDTH  = 32,
  parameter logic [4:0] ADD_OP      = 5'b00011,
  parameter int         MEM_TIMEOUT = 16
) (
  input  logic                  Clock,
  input  logic                  clear,
`ifdef SINGLE_STEP_EN
  input  logic                  step,
`endif
  input  logic [DATA_WIDTH-1:0] IR,
  input  logic                  con_ff_bit,
  input  logic                  memory_done,
  output logic HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
  output logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in,
  output logic Gra, Grb, Grc, Rin, Rout, BAout,
  output logic [4:0] opcode,
  output logic IncPC,
  output logic Mem_Read, Mem_Write, Mem_enable512x32,
  output logic halted,
  output logic mem_fault,
  output logic illegal_op
);

  typedef enum logic [2:0] {S_RESET, S_T0, S_T1, S_T2, S_EX, S_HALT} state_t;
  typedef enum logic [4:0] {C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_NEGNOT,
                            C_BR, C_JAL, C_JR, C_IN, C_OUT, C_MFLO, C_MFHI,
                            C_NOP, C_HALT, C_ILL} cls_t;

  localparam logic [15:0] CNT_LOAD = 16'(MEM_TIMEOUT - 1);

  state_t      state_q;
  logic [2:0]  step_q;
  logic [15:0] cnt_q;
  logic        first_q;
  logic        fault_q;

  logic [4:0]  op;
  cls_t        cls;
  logic [2:0]  last_step;
  logic        is_wait;
  logic        timeout_d;
  logic        go;
  logic        unused_ir;

  assign op        = IR[DATA_WIDTH-1 -: 5];
  assign unused_ir = ^IR[DATA_WIDTH-6:0];

`ifdef SINGLE_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif

  always_comb begin
    cls = C_ILL;
    if      (op == 5'd0)  cls = C_LD;
    else if (op == 5'd1)  cls = C_LDI;
    else if (op == 5'd2)  cls = C_ST;
    else if (op <= 5'd11) cls = C_ALU;
    else if (op <= 5'd14) cls = C_IMM;
    else if (op <= 5'd16) cls = C_MULDIV;
    else if (op <= 5'd18) cls = C_NEGNOT;
    else if (op == 5'd19) cls = C_BR;
    else if (op == 5'd20) cls = C_JAL;
    else if (op == 5'd21) cls = C_JR;
    else if (op == 5'd22) cls = C_IN;
    else if (op == 5'd23) cls = C_OUT;
    else if (op == 5'd24) cls = C_MFLO;
    else if (op == 5'd25) cls = C_MFHI;
    else if (op == 5'd26) cls = C_NOP;
    else if (op == 5'd27) cls = C_HALT;
  end

  always_comb begin
    case (cls)
      C_ALU, C_IMM, C_LDI: last_step = 3'd2;
      C_LD, C_ST:          last_step = 3'd4;
      C_MULDIV, C_BR:      last_step = 3'd3;
      C_NEGNOT, C_JAL:     last_step = 3'd1;
      default:             last_step = 3'd0;
    endcase
  end

  // ld waits in step 3, st in step 4; T1 is the instruction fetch wait.
  assign is_wait = (state_q == S_T1) ||
                   (state_q == S_EX && ((cls == C_LD && step_q == 3'd3) ||
                                        (cls == C_ST && step_q == 3'd4)));
  // memory_done on the last allowed cycle still wins over the timeout.
  assign timeout_d = (MEM_TIMEOUT != 0) && is_wait && !memory_done && (cnt_q == 16'd0);

  always_ff @(posedge Clock) begin
    if (clear) begin
      state_q <= S_RESET;
      step_q  <= 3'd0;
      cnt_q   <= 16'd0;
      first_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      // Down-counter reloads in every non-wait cycle, so each wait starts fresh.
      cnt_q   <= is_wait ? cnt_q - 16'd1 : CNT_LOAD;
      first_q <= (state_q != S_T1);
      if (timeout_d) begin
        state_q <= S_HALT;
        fault_q <= 1'b1;
      end else begin
        case (state_q)
          S_RESET: state_q <= S_T0;
          S_T0:    if (go) state_q <= S_T1;
          S_T1:    if (memory_done) state_q <= S_T2;
          S_T2: begin
            state_q <= S_EX;
            step_q  <= 3'd0;
          end
          S_EX: begin
            if (!(is_wait && !memory_done)) begin
              if (cls == C_HALT)            state_q <= S_HALT;
              else if (step_q == last_step) state_q <= S_T0;
              else                          step_q  <= step_q + 3'd1;
            end
          end
          S_HALT:  state_q <= S_HALT;
          default: state_q <= S_RESET;
        endcase
      end
    end
  end

  always_comb begin
    HIout = 1'b0; LOout = 1'b0; Zhi_out = 1'b0; Zlo_out = 1'b0;
    PCout = 1'b0; MDRout = 1'b0; Inport_out = 1'b0; Cout = 1'b0;
    MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; HIin = 1'b0; LOin = 1'b0; CONin = 1'b0; outport_in = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    opcode = 5'd0; IncPC = 1'b0;
    Mem_Read = 1'b0; Mem_Write = 1'b0; Mem_enable512x32 = 1'b0;
    halted = (state_q == S_HALT);
    mem_fault = fault_q;
    illegal_op = 1'b0;
    case (state_q)
      S_T0: if (go) begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin
        Mem_Read = 1'b1; Mem_enable512x32 = 1'b1; MDRin = memory_done;
        if (first_q) begin Zlo_out = 1'b1; PCin = 1'b1; end
      end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_EX: begin
        case (cls)
          C_ALU, C_IMM: case (step_q)
            3'd0: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            3'd1: begin
              Zin = 1'b1; opcode = op;
              if (cls == C_ALU) begin Grc = 1'b1; Rout = 1'b1; end
              else Cout = 1'b1;
            end
            default: begin Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          endcase
          C_LDI, C_LD, C_ST: case (step_q)
            3'd0: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; opcode = ADD_OP; end
            3'd1: begin Cout = 1'b1; Zin = 1'b1; opcode = ADD_OP; end
            3'd2: begin
              Zlo_out = 1'b1;
              if (cls == C_LDI) begin Gra = 1'b1; Rin = 1'b1; end
              else MARin = 1'b1;
            end
            3'd3: begin
              if (cls == C_LD) begin
                Mem_Read = 1'b1; Mem_enable512x32 = 1'b1; MDRin = memory_done;
              end else begin
                Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
              end
            end
            default: begin
              if (cls == C_LD) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              else begin Mem_Write = 1'b1; Mem_enable512x32 = 1'b1; end
            end
          endcase
          C_MULDIV: case (step_q)
            3'd0: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            3'd1: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; end
            3'd2: begin Zlo_out = 1'b1; LOin = 1'b1; end
            default: begin Zhi_out = 1'b1; HIin = 1'b1; end
          endcase
          C_NEGNOT:
            if (step_q == 3'd0) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; end
            else begin Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_BR: case (step_q)
            3'd0: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
            3'd1: begin PCout = 1'b1; Yin = 1'b1; end
            3'd2: begin Cout = 1'b1; Zin = 1'b1; opcode = ADD_OP; end
            default: if (con_ff_bit) begin Zlo_out = 1'b1; PCin = 1'b1; end
          endcase
          C_JAL:
            if (step_q == 3'd0) begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
            else begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          C_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          C_IN:   begin Inport_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_OUT:  begin Gra = 1'b1; Rout = 1'b1; outport_in = 1'b1; end
          C_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ILL:  illegal_op = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam int TMO = 16;
  localparam logic [4:0] ADD = 5'b00011;

  logic        Clock, clear;
  logic [31:0] IR;
  logic        con_ff_bit, memory_done;
  logic HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0] opcode;
  logic IncPC, Mem_Read, Mem_Write, Mem_enable512x32;
  logic halted, mem_fault, illegal_op;

  control_sequencer #(.DATA_WIDTH(32), .ADD_OP(ADD), .MEM_TIMEOUT(TMO)) dut (
    .Clock(Clock), .clear(clear), .IR(IR), .con_ff_bit(con_ff_bit), .memory_done(memory_done),
    .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out), .PCout(PCout),
    .MDRout(MDRout), .Inport_out(Inport_out), .Cout(Cout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .CONin(CONin), .outport_in(outport_in),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .opcode(opcode), .IncPC(IncPC), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Mem_enable512x32(Mem_enable512x32), .halted(halted), .mem_fault(mem_fault),
    .illegal_op(illegal_op));

  typedef struct packed {
    logic HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic [4:0] opcode;
    logic IncPC, Mem_Read, Mem_Write, Mem_enable512x32;
    logic halted, mem_fault, illegal_op;
  } sig_t;

  sig_t act;
  assign act = {HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
                MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in,
                Gra, Grb, Grc, Rin, Rout, BAout, opcode,
                IncPC, Mem_Read, Mem_Write, Mem_enable512x32, halted, mem_fault, illegal_op};

  int checks = 0;
  int failures = 0;

  // Per-cycle scoreboard: stimulus and the expected strobe word for that cycle.
  sig_t        exp_q[$];
  logic        done_q[$];
  logic        con_q[$];
  logic [31:0] ir_q[$];
  logic [31:0] cur_ir = 32'h0;
  logic        cur_con = 1'b0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check_sig(input string name, input int k, input sig_t got, input sig_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%09h exp=%09h", name, k, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic emit(input sig_t e, input logic d);
    exp_q.push_back(e); done_q.push_back(d); ir_q.push_back(cur_ir); con_q.push_back(cur_con);
  endtask

  task automatic emit_halt(input int n, input bit fault);
    sig_t e;
    for (int i = 0; i < n; i++) begin
      e = '0; e.halted = 1'b1; e.mem_fault = fault;
      emit(e, 1'b0);
    end
  endtask

  // Memory responds on wait cycle d (0-based); d >= TMO means it never answers in time.
  task automatic mem_wait(input bit wr, input int d, input bit fetch, output bit ok);
    sig_t e;
    int n;
    logic dn;
    ok = !(d >= TMO);
    n  = ok ? d + 1 : TMO;
    for (int i = 0; i < n; i++) begin
      dn = ok && (i == n - 1);
      e = '0; e.Mem_enable512x32 = 1'b1;
      if (wr) e.Mem_Write = 1'b1; else begin e.Mem_Read = 1'b1; e.MDRin = dn; end
      if (fetch && i == 0) begin e.Zlo_out = 1'b1; e.PCin = 1'b1; end
      emit(e, dn);
    end
    if (!ok) emit_halt(4, 1'b1);
  endtask

  task automatic gen_instr(input logic [4:0] op, input bit con, input int df, input int dd);
    sig_t e;
    bit ok;
    cur_con = con;
    e = '0; e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zin = 1; emit(e, 0);
    mem_wait(1'b0, df, 1'b1, ok);
    if (!ok) return;
    e = '0; e.MDRout = 1; e.IRin = 1; emit(e, 0);
    cur_ir = {op, 27'($urandom)};
    if (op <= 5'd2) begin
      e = '0; e.Grb = 1; e.BAout = 1; e.Yin = 1; e.opcode = ADD; emit(e, 0);
      e = '0; e.Cout = 1; e.Zin = 1; e.opcode = ADD; emit(e, 0);
      if (op == 5'd1) begin
        e = '0; e.Zlo_out = 1; e.Gra = 1; e.Rin = 1; emit(e, 0);
      end else begin
        e = '0; e.Zlo_out = 1; e.MARin = 1; emit(e, 0);
        if (op == 5'd0) begin
          mem_wait(1'b0, dd, 1'b0, ok);
          if (!ok) return;
          e = '0; e.MDRout = 1; e.Gra = 1; e.Rin = 1; emit(e, 0);
        end else begin
          e = '0; e.Gra = 1; e.Rout = 1; e.MDRin = 1; emit(e, 0);
          mem_wait(1'b1, dd, 1'b0, ok);
        end
      end
    end else if (op <= 5'd14) begin
      e = '0; e.Grb = 1; e.Rout = 1; e.Yin = 1; emit(e, 0);
      e = '0; e.Zin = 1; e.opcode = op;
      if (op <= 5'd11) begin e.Grc = 1; e.Rout = 1; end else e.Cout = 1;
      emit(e, 0);
      e = '0; e.Zlo_out = 1; e.Gra = 1; e.Rin = 1; emit(e, 0);
    end else if (op <= 5'd16) begin
      e = '0; e.Gra = 1; e.Rout = 1; e.Yin = 1; emit(e, 0);
      e = '0; e.Grb = 1; e.Rout = 1; e.Zin = 1; e.opcode = op; emit(e, 0);
      e = '0; e.Zlo_out = 1; e.LOin = 1; emit(e, 0);
      e = '0; e.Zhi_out = 1; e.HIin = 1; emit(e, 0);
    end else if (op <= 5'd18) begin
      e = '0; e.Grb = 1; e.Rout = 1; e.Zin = 1; e.opcode = op; emit(e, 0);
      e = '0; e.Zlo_out = 1; e.Gra = 1; e.Rin = 1; emit(e, 0);
    end else begin
      e = '0;
      case (op)
        5'd19: begin
          e.Gra = 1; e.Rout = 1; e.CONin = 1; emit(e, 0);
          e = '0; e.PCout = 1; e.Yin = 1; emit(e, 0);
          e = '0; e.Cout = 1; e.Zin = 1; e.opcode = ADD; emit(e, 0);
          e = '0; if (con) begin e.Zlo_out = 1; e.PCin = 1; end
        end
        5'd20: begin
          e.PCout = 1; e.Grb = 1; e.Rin = 1; emit(e, 0);
          e = '0; e.Gra = 1; e.Rout = 1; e.PCin = 1;
        end
        5'd21: begin e.Gra = 1; e.Rout = 1; e.PCin = 1; end
        5'd22: begin e.Inport_out = 1; e.Gra = 1; e.Rin = 1; end
        5'd23: begin e.Gra = 1; e.Rout = 1; e.outport_in = 1; end
        5'd24: begin e.LOout = 1; e.Gra = 1; e.Rin = 1; end
        5'd25: begin e.HIout = 1; e.Gra = 1; e.Rin = 1; end
        5'd26, 5'd27: ;
        default: e.illegal_op = 1;
      endcase
      emit(e, 0);
      if (op == 5'd27) emit_halt(20, 1'b0);
    end
  endtask

  task automatic run_q(input string name);
    sig_t e;
    int k = 0;
    while (exp_q.size() > 0) begin
      @(posedge Clock); #1;
      IR = ir_q.pop_front(); con_ff_bit = con_q.pop_front(); memory_done = done_q.pop_front();
      e = exp_q.pop_front();
      @(negedge Clock);
      check_sig(name, k, act, e);
      checks++;
      if ($countones({HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout}) > 1) begin
        failures++;
        $display("FAIL bus_excl[%0d] got=%0d sources exp<=1", k,
                 $countones({HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout}));
      end
      k++;
    end
    memory_done = 1'b0;
  endtask

  task automatic do_reset(input string name);
    @(posedge Clock); #1;
    clear = 1'b1; memory_done = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check_sig({name, "_held"}, 0, act, '0);
    @(posedge Clock); #1;
    clear = 1'b0;
    @(negedge Clock);
    check_sig({name, "_release"}, 0, act, '0);
  endtask

  // Hand-derived per-instruction totals with fetch answering on wait cycle 1
  // and data on wait cycle 2 (three wait cycles).
  typedef struct {
    logic [4:0] op; bit con; int len; int rin; int pcin; int ill;
  } tv_t;
  tv_t tbl[16];

  task automatic run_tbl_entry(input int i);
    int len = 0, rin = 0, pcin = 0, ill = 0, wc = 0;
    bit phase = 0, fin = 0;
    IR = {tbl[i].op, 27'($urandom)};
    con_ff_bit = tbl[i].con;
    for (int c = 0; c < 60 && !fin; c++) begin
      @(posedge Clock); #1;
      if (Mem_enable512x32) begin
        memory_done = (wc == (phase ? 2 : 1));
        wc++;
      end else begin
        memory_done = 1'b0; wc = 0;
      end
      @(negedge Clock);
      if (phase) begin
        if (PCout && IncPC) fin = 1;
        else begin len += int'(Rin) * 0 + 1; rin += int'(Rin); pcin += int'(PCin); ill += int'(illegal_op); end
      end
      if (IRin) phase = 1;
    end
    memory_done = 1'b0;
    if (!fin) begin
      checks++; failures++;
      $display("FAIL tbl%0d_timeout got=no_T0 exp=T0", i);
    end else begin
      check_int($sformatf("tbl%0d_len", i), len, tbl[i].len);
      check_int($sformatf("tbl%0d_rin", i), rin, tbl[i].rin);
      check_int($sformatf("tbl%0d_pcin", i), pcin, tbl[i].pcin);
      check_int($sformatf("tbl%0d_ill", i), ill, tbl[i].ill);
    end
  endtask

  initial begin
    sig_t e;
    logic [4:0] rop;
    clear = 1'b1; IR = 32'h0; con_ff_bit = 1'b0; memory_done = 1'b0;

    tbl[0]  = '{5'd3,  0, 3, 1, 0, 0};  // add
    tbl[1]  = '{5'd12, 0, 3, 1, 0, 0};  // addi
    tbl[2]  = '{5'd1,  0, 3, 1, 0, 0};  // ldi
    tbl[3]  = '{5'd0,  0, 7, 1, 0, 0};  // ld
    tbl[4]  = '{5'd2,  0, 7, 0, 0, 0};  // st
    tbl[5]  = '{5'd16, 0, 4, 0, 0, 0};  // mul
    tbl[6]  = '{5'd17, 0, 2, 1, 0, 0};  // neg
    tbl[7]  = '{5'd19, 0, 4, 0, 0, 0};  // br not taken
    tbl[8]  = '{5'd19, 1, 4, 0, 1, 0};  // br taken
    tbl[9]  = '{5'd20, 0, 2, 1, 1, 0};  // jal
    tbl[10] = '{5'd21, 0, 1, 0, 1, 0};  // jr
    tbl[11] = '{5'd22, 0, 1, 1, 0, 0};  // in
    tbl[12] = '{5'd23, 0, 1, 0, 0, 0};  // out
    tbl[13] = '{5'd25, 0, 1, 1, 0, 0};  // mfhi
    tbl[14] = '{5'd26, 0, 1, 0, 0, 0};  // nop
    tbl[15] = '{5'd29, 0, 1, 0, 0, 1};  // illegal

    do_reset("reset");

    gen_instr(5'd3, 0, 2, 0);        // add R1,R2,R3
    gen_instr(5'd2, 0, 1, 4);        // st, done on 5th wait cycle
    gen_instr(5'd19, 0, 0, 0);       // br not taken
    gen_instr(5'd19, 1, 3, 0);       // br taken
    gen_instr(5'd0, 0, 1, 3);        // ld
    gen_instr(5'd26, 0, TMO - 1, 0); // done exactly at the limit
    gen_instr(5'd0, 0, 0, TMO - 1);
    run_q("planned");

    for (int n = 0; n < 40; n++) begin
      rop = 5'($urandom_range(0, 31));
      if (rop == 5'd27) rop = 5'd26;
      gen_instr(rop, 1'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
    end
    run_q("random");

    gen_instr(5'd30, 0, 1, 0);
    gen_instr(5'd3, 0, 0, 0);
    gen_instr(5'd27, 0, 1, 0);
    run_q("ill_halt");
    do_reset("after_halt");

    gen_instr(5'd26, 0, TMO + 2, 0);
    run_q("fetch_timeout");
    do_reset("after_fetch_fault");

    gen_instr(5'd0, 0, 1, TMO + 5);
    run_q("load_timeout");
    do_reset("after_load_fault");

    // clear in the middle of a fetch wait
    e = '0; e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zin = 1; emit(e, 0);
    e = '0; e.Mem_Read = 1; e.Mem_enable512x32 = 1; e.Zlo_out = 1; e.PCin = 1; emit(e, 0);
    e = '0; e.Mem_Read = 1; e.Mem_enable512x32 = 1; emit(e, 0);
    run_q("abort");
    do_reset("abort_clear");

    for (int i = 0; i < 16; i++) run_tbl_entry(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
